// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave responder: FSM states,
// bits per byte and the R/W bit encoding of the address byte.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_slave_state_t;

  localparam int unsigned I2C_BITS_PER_BYTE = 8;

  // R/W bit of the address byte, matching i2c_enum_type (WRITE=0, READ=1)
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_slave_line_sync.sv
// Two-flop synchronizers for SCL/SDA followed by a registered edge detector
// producing single-cycle SCL edge, START and STOP pulses.
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_bit
);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;
  logic scl_rise_q, scl_fall_q, start_q, stop_q;
  logic scl_rise_d, scl_fall_d, start_d, stop_d;

  always_comb begin
    scl_rise_d = scl_sync_q & ~scl_prev_q;
    scl_fall_d = ~scl_sync_q & scl_prev_q;
    start_d    = scl_sync_q & scl_prev_q & ~sda_sync_q & sda_prev_q;
    stop_d     = scl_sync_q & scl_prev_q & sda_sync_q & ~sda_prev_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  // sda_prev_q is the SDA value seen in the same cycle the registered edge was detected
  assign sda_bit   = sda_prev_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave answering one 7-bit address, backed by a byte register memory
// with an auto-incrementing pointer shared by write and read transfers.
module i2c_slave_responder
  import i2c_slave_pkg::*;
#(
  parameter int unsigned I2C_ADDR_WIDTH = 7,
  parameter int unsigned I2C_DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH      = 16,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_o,
  output logic                         busy_o,
  output logic                         wr_stb_o,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr_o,
  output logic [I2C_DATA_WIDTH-1:0]    wr_data_o
);

  localparam int unsigned PW = $clog2(MEM_DEPTH);
  localparam int unsigned DW = I2C_DATA_WIDTH;
  localparam logic [3:0] BIT_LAST = 4'(I2C_BITS_PER_BYTE - 1);
  localparam logic [3:0] BIT_ALL  = 4'(I2C_BITS_PER_BYTE);

  logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

  i2c_line_sync u_line_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_bit  (sda_bit)
  );

  i2c_slave_state_t state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          ptr_load_q, ptr_load_d;
  logic          rw_q, rw_d;
  logic          sda_o_q, sda_o_d;
  logic          busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d;
  logic [PW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [DW-1:0] mem_q [MEM_DEPTH];

  logic [DW-1:0] byte_in;
  logic          last_bit;
  logic          addr_match;

  assign byte_in    = {shift_q[DW-2:0], sda_bit};
  assign last_bit   = (bit_cnt_q == BIT_LAST);
  assign addr_match = (byte_in[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The ACK states use bit_cnt as a phase flag: 0 = ACK pulse pending, 1 = ACK clocked
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ST_ADDR;
    end else if (stop_det) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR:     if (scl_rise && last_bit) state_d = addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK: if (scl_fall && bit_cnt_q != 4'd0)
                       state_d = (rw_q == I2C_RW_READ) ? ST_RD_BYTE : ST_WR_BYTE;
        ST_WR_BYTE:  if (scl_rise && last_bit) state_d = ST_WR_ACK;
        ST_WR_ACK:   if (scl_fall && bit_cnt_q != 4'd0) state_d = ST_WR_BYTE;
        ST_RD_BYTE:  if (scl_fall && bit_cnt_q == BIT_ALL) state_d = ST_RD_ACK;
        ST_RD_ACK: begin
          if (scl_rise && sda_bit) state_d = ST_WAIT_STOP;
          else if (scl_fall && bit_cnt_q != 4'd0) state_d = ST_RD_BYTE;
        end
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    ptr_load_d = ptr_load_q;
    rw_d       = rw_q;
    sda_o_d    = sda_o_q;
    busy_d     = busy_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (start_det) begin
      bit_cnt_d = 4'd0;
      sda_o_d   = 1'b1;
    end else if (stop_det) begin
      bit_cnt_d = 4'd0;
      sda_o_d   = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d = 4'd0;
              rw_d      = byte_in[0];
              if (addr_match) begin
                busy_d     = 1'b1;
                ptr_load_d = (byte_in[0] == I2C_RW_WRITE);
              end
            end
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_rise) bit_cnt_d = 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_o_d = 1'b0;
            end else begin
              bit_cnt_d = 4'd0;
              if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
                shift_d = mem_q[ptr_q];
                sda_o_d = mem_q[ptr_q][DW-1];
              end else begin
                sda_o_d = 1'b1;
              end
            end
          end
        end
        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d = 4'd0;
              if (ptr_load_q) begin
                ptr_d      = byte_in[PW-1:0];
                ptr_load_d = 1'b0;
              end else begin
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                ptr_d     = ptr_q + 1'b1;
              end
            end
          end
        end
        ST_RD_BYTE: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == BIT_ALL) begin
              sda_o_d   = 1'b1;
              bit_cnt_d = 4'd0;
            end else if (bit_cnt_q != 4'd0) begin
              shift_d = {shift_q[DW-2:0], 1'b0};
              sda_o_d = shift_q[DW-2];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr_q + 1'b1;
            if (!sda_bit) bit_cnt_d = 4'd1;
          end
          if (scl_fall && bit_cnt_q != 4'd0) begin
            bit_cnt_d = 4'd0;
            shift_d   = mem_q[ptr_q];
            sda_o_d   = mem_q[ptr_q][DW-1];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      ptr_q      <= '0;
      ptr_load_q <= 1'b0;
      rw_q       <= 1'b0;
      sda_o_q    <= 1'b1;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      ptr_load_q <= ptr_load_d;
      rw_q       <= rw_d;
      sda_o_q    <= sda_o_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_stb_d) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign sda_o     = sda_o_q;
  assign busy_o    = busy_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule
